// File: rtl/key_step_pkg.sv
// Shared encodings and default 50 MHz timing for the key step controller.
package key_step_pkg;

  localparam logic [2:0] ST_IDLE         = 3'd0;
  localparam logic [2:0] ST_PRESS_WAIT   = 3'd1;
  localparam logic [2:0] ST_HELD         = 3'd2;
  localparam logic [2:0] ST_REPEAT       = 3'd3;
  localparam logic [2:0] ST_RELEASE_WAIT = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE         = ST_IDLE,
    S_PRESS_WAIT   = ST_PRESS_WAIT,
    S_HELD         = ST_HELD,
    S_REPEAT       = ST_REPEAT,
    S_RELEASE_WAIT = ST_RELEASE_WAIT
  } state_e;

  localparam int DEF_DEBOUNCE_CYCLES = 500000;
  localparam int DEF_REPEAT_DELAY    = 25000000;
  localparam int DEF_REPEAT_PERIOD   = 5000000;
  localparam int DEF_CNT_W           = 8;
  localparam int DEF_TMR_W           = 25;

endpackage

// File: rtl/key_step_ctrl_if.sv
// Key/step bundle between the button front end and the accumulator datapath.
// Handshake: none; step is a one-cycle strobe the consumer samples on any edge it is high.
interface key_step_ctrl_if #(
  parameter int CNT_W = 8
);
  logic             key_n;
  logic             auto_en;
  logic             step;
  logic             pressed;
  logic [CNT_W-1:0] step_count;

  modport master (
    output key_n, auto_en,
    input  step, pressed, step_count
  );

  modport slave (
    input  key_n, auto_en,
    output step, pressed, step_count
  );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer with a configurable reset level.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic q_o
);
  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;
endmodule

// File: rtl/key_step_ctrl.sv
// Debounces the active-low button into single-cycle step pulses with optional
// hold-to-repeat, and counts the steps issued.
module key_step_ctrl
  import key_step_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter int CNT_W           = DEF_CNT_W,
  parameter int TMR_W           = DEF_TMR_W
) (
  input  logic                  clk,
  input  logic                  reset_n,
  key_step_ctrl_if.slave        kif,
  output logic [2:0]            dbg_state_o
);
  localparam logic [TMR_W-1:0] DB_LAST  = TMR_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TMR_W-1:0] RD_LAST  = TMR_W'(REPEAT_DELAY - 1);
  localparam logic [TMR_W-1:0] RP_LAST  = TMR_W'(REPEAT_PERIOD - 1);

  logic             key_sync;
  logic             raw;
  state_e           state_q;
  logic [TMR_W-1:0] timer_q;
  logic [TMR_W-1:0] timer_d;
  logic             step_q;
  logic             pressed_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Reset value 1 keeps the key reading as released until real samples arrive.
  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (kif.key_n),
    .q_o     (key_sync)
  );

  assign raw     = ~key_sync;
  assign timer_d = timer_q + 1'b1;
  assign cnt_d   = cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      step_q    <= 1'b0;
      pressed_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      step_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (raw) begin
            state_q <= S_PRESS_WAIT;
            timer_q <= '0;
          end
        end
        S_PRESS_WAIT: begin
          if (!raw) begin
            state_q <= S_IDLE;
          end else if (timer_q == DB_LAST) begin
            state_q   <= S_HELD;
            timer_q   <= '0;
            step_q    <= 1'b1;
            pressed_q <= 1'b1;
            cnt_q     <= cnt_d;
          end else begin
            timer_q <= timer_d;
          end
        end
        S_HELD: begin
          // Timer parks at the repeat threshold while auto_en is low, so it never wraps.
          if (!raw) begin
            state_q <= S_RELEASE_WAIT;
            timer_q <= '0;
          end else if (timer_q == RD_LAST) begin
            if (kif.auto_en) begin
              state_q <= S_REPEAT;
              timer_q <= '0;
              step_q  <= 1'b1;
              cnt_q   <= cnt_d;
            end
          end else begin
            timer_q <= timer_d;
          end
        end
        S_REPEAT: begin
          if (!raw) begin
            state_q <= S_RELEASE_WAIT;
            timer_q <= '0;
          end else if (!kif.auto_en) begin
            state_q <= S_HELD;
            timer_q <= '0;
          end else if (timer_q == RP_LAST) begin
            timer_q <= '0;
            step_q  <= 1'b1;
            cnt_q   <= cnt_d;
          end else begin
            timer_q <= timer_d;
          end
        end
        S_RELEASE_WAIT: begin
          if (raw) begin
            state_q <= S_HELD;
            timer_q <= '0;
          end else if (timer_q == DB_LAST) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            pressed_q <= 1'b0;
          end else begin
            timer_q <= timer_d;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          timer_q   <= '0;
          pressed_q <= 1'b0;
        end
      endcase
    end
  end

  assign kif.step       = step_q;
  assign kif.pressed    = pressed_q;
  assign kif.step_count = cnt_q;
  assign dbg_state_o    = state_q;
endmodule

// File: tb/tb_key_step_ctrl.sv
// Directed bench for key_step_ctrl with short debounce/repeat timings.
module tb_key_step_ctrl;
  import key_step_pkg::*;

  localparam int CNT_W = 3;

  logic       clk;
  logic       reset_n;
  logic [2:0] dbg_state;
  int         n_checks;
  int         n_err;
  logic [CNT_W-1:0] exp_cnt;

  key_step_ctrl_if #(.CNT_W(CNT_W)) kif ();

  key_step_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (10),
    .REPEAT_PERIOD   (3),
    .CNT_W           (CNT_W),
    .TMR_W           (5)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .kif         (kif),
    .dbg_state_o (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock edge, then compare outputs against the step/pressed model.
  task automatic cyc_check(input string tag, input bit exp_step, input bit exp_pressed);
    tick();
    if (exp_step) exp_cnt = exp_cnt + 1'b1;
    chk({tag, "_step"}, 32'(kif.step), 32'(exp_step));
    chk({tag, "_pressed"}, 32'(kif.pressed), 32'(exp_pressed));
    chk({tag, "_count"}, 32'(kif.step_count), 32'(exp_cnt));
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    exp_cnt = '0;
    chk("reset_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("reset_count", 32'(kif.step_count), 0);
    chk("reset_pressed", 32'(kif.pressed), 0);
  endtask

  task automatic release_key(input string tag);
    kif.key_n = 1'b1;
    for (int c = 0; c < 10; c++) cyc_check(tag, 1'b0, c < 6);
    chk({tag, "_idle"}, 32'(dbg_state), 32'(ST_IDLE));
  endtask

  initial begin
    n_checks    = 0;
    n_err       = 0;
    exp_cnt     = '0;
    reset_n     = 1'b0;
    kif.key_n   = 1'b1;
    kif.auto_en = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_step", 32'(kif.step), 0);
    chk("rst_pressed", 32'(kif.pressed), 0);
    chk("rst_count", 32'(kif.step_count), 0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) cyc_check("idle", 1'b0, 1'b0);

    // Clean press: step right after edge 6, then nothing more
    kif.key_n = 1'b0;
    for (int c = 0; c < 20; c++) cyc_check("clean", c == 6, c >= 6);
    chk("clean_held", 32'(dbg_state), 32'(ST_HELD));
    release_key("clean_rel");

    // Press bounce: low 2, high 1, low 2, then high
    for (int c = 0; c < 12; c++) begin
      kif.key_n = !(c == 0 || c == 1 || c == 3 || c == 4);
      cyc_check("bounce", 1'b0, 1'b0);
    end
    kif.key_n = 1'b0;
    for (int c = 0; c < 10; c++) cyc_check("post_bounce", c == 6, c >= 6);
    release_key("pb_rel");

    // Release bounce: high 2, low 1, then high; pressed drops 9 edges in
    kif.key_n = 1'b0;
    for (int c = 0; c < 10; c++) cyc_check("rb_press", c == 6, c >= 6);
    for (int c = 0; c < 13; c++) begin
      kif.key_n = (c != 2);
      cyc_check("rel_bounce", 1'b0, c < 9);
      if (c == 4) chk("rb_back_held", 32'(dbg_state), 32'(ST_HELD));
    end

    // Auto-repeat from a zero count so the 3-bit counter wraps
    apply_reset();
    kif.auto_en = 1'b1;
    kif.key_n   = 1'b0;
    for (int c = 0; c < 40; c++)
      cyc_check("auto", (c == 6) || (c >= 16 && ((c - 16) % 3) == 0), c >= 6);
    chk("auto_wrapped", 32'(kif.step_count), 1);
    // auto_en falls on the edge the repeat timer would fire: no pulse
    kif.auto_en = 1'b0;
    for (int c = 40; c < 56; c++) cyc_check("auto_off", 1'b0, 1'b1);
    chk("auto_off_held", 32'(dbg_state), 32'(ST_HELD));
    // Delay timer has parked at its threshold, so re-enabling fires at once
    kif.auto_en = 1'b1;
    cyc_check("auto_resume", 1'b1, 1'b1);
    chk("auto_resume_state", 32'(dbg_state), 32'(ST_REPEAT));
    kif.auto_en = 1'b0;
    cyc_check("auto_drop", 1'b0, 1'b1);
    release_key("auto_rel");

    // Reset while HELD with step_count = 5 and the key still down
    apply_reset();
    kif.auto_en = 1'b1;
    kif.key_n   = 1'b0;
    for (int c = 0; c < 26; c++)
      cyc_check("pre_rst", (c == 6) || (c >= 16 && ((c - 16) % 3) == 0), c >= 6);
    kif.auto_en = 1'b0;
    for (int c = 26; c < 30; c++) cyc_check("pre_rst_held", 1'b0, 1'b1);
    chk("pre_rst_count", 32'(kif.step_count), 5);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    exp_cnt = '0;
    chk("midrst_count", 32'(kif.step_count), 0);
    chk("midrst_pressed", 32'(kif.pressed), 0);
    chk("midrst_state", 32'(dbg_state), 32'(ST_IDLE));
    for (int c = 0; c < 13; c++) cyc_check("after_rst", c == 6, c >= 6);
    release_key("after_rst_rel");

    // Raw drops on the same edge PRESS_WAIT hits terminal count
    for (int c = 0; c < 11; c++) begin
      kif.key_n = (c >= 4);
      cyc_check("simul", 1'b0, 1'b0);
      if (c == 5) chk("simul_pw", 32'(dbg_state), 32'(ST_PRESS_WAIT));
      if (c == 6) chk("simul_idle", 32'(dbg_state), 32'(ST_IDLE));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
